// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the two-requester memory port arbiter: requester A/B handshakes plus the shared memory port.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 16
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [15:0]   a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [15:0]   a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [15:0]   b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [15:0]   b_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: A has fixed priority, B is protected from starvation by a saturating deny counter.
// Read data returns one cycle after the grant, steered by a registered owner tag.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]    starve_q, starve_d;
  owner_t        owner_q, owner_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   a_rdata_q, a_rdata_d;
  logic [15:0]   b_rdata_q, b_rdata_d;
  logic          b_starved;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q  <= 4'd0;
      owner_q   <= OWN_A;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 16'd0;
      a_rdata_q <= 16'd0;
      b_rdata_q <= 16'd0;
    end else begin
      starve_q  <= starve_d;
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Grants are purely combinational and forced low while reset is held, so nothing reaches memory during reset.
  always_comb begin
    starve_d      = starve_q;
    owner_d       = owner_q;
    rd_pend_d     = 1'b0;
    b_starved     = (starve_q == LIMIT);
    bus.a_gnt     = 1'b0;
    bus.b_gnt     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.a_rvalid  = 1'b0;
    bus.b_rvalid  = 1'b0;
    bus.a_rdata   = a_rdata_q;
    bus.b_rdata   = b_rdata_q;
    bus.busy      = rd_pend_q;

    if (reset) begin
      if (bus.a_req && !(bus.b_req && b_starved)) begin
        bus.a_gnt = 1'b1;
      end else if (bus.b_req) begin
        bus.b_gnt = 1'b1;
      end
    end

    if (bus.a_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.a_we;
      bus.mem_addr  = bus.a_addr;
      bus.mem_wdata = bus.a_wdata;
      rd_pend_d     = !bus.a_we;
      if (!bus.a_we) begin
        owner_d = OWN_A;
      end
    end else if (bus.b_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.b_we;
      bus.mem_addr  = bus.b_addr;
      bus.mem_wdata = bus.b_wdata;
      rd_pend_d     = !bus.b_we;
      if (!bus.b_we) begin
        owner_d = OWN_B;
      end
    end

    if (!bus.b_req || bus.b_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q < LIMIT) begin
      starve_d = starve_q + 4'd1;
    end

    // Memory data is only valid in the cycle after the strobe, so pass it through then and hold it afterwards.
    if (rd_pend_q) begin
      if (owner_q == OWN_A) begin
        bus.a_rvalid = 1'b1;
        bus.a_rdata  = bus.mem_rdata;
      end else begin
        bus.b_rvalid = 1'b1;
        bus.b_rdata  = bus.mem_rdata;
      end
    end

    addr_d    = bus.mem_addr;
    wdata_d   = bus.mem_wdata;
    a_rdata_d = bus.a_rdata;
    b_rdata_d = bus.b_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants and read returns,
// a negedge monitor pops and compares them against the DUT.
module tb_mem_port_arbiter;

  localparam int AW = 16;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } gnt_exp_t;

  typedef struct {
    int          cyc;
    logic [1:0]  port;
    logic [15:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] held_addr = 16'd0;
  logic [15:0] held_wdata = 16'd0;
  logic [15:0] mem_model [0:65535];
  gnt_exp_t    gnt_q [$];
  rd_exp_t     rd_q [$];

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT(4),
    .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-before-write memory with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_model[bus.mem_addr];
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
                                input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd,
                                input logic [1:0] exp_gnt, input logic exp_rd, input logic [15:0] exp_data);
    gnt_exp_t e;
    rd_exp_t  r;
    @(posedge clk);
    #1;
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    e.cyc = cyc;
    e.gnt = exp_gnt;
    case (exp_gnt)
      2'b01:   begin e.we = aw; held_addr = aa; held_wdata = ad; end
      2'b10:   begin e.we = bw; held_addr = ba; held_wdata = bd; end
      default: e.we = 1'b0;
    endcase
    e.addr  = held_addr;
    e.wdata = held_wdata;
    gnt_q.push_back(e);
    if (exp_rd) begin
      r.cyc  = cyc + 1;
      r.port = exp_gnt;
      r.data = exp_data;
      rd_q.push_back(r);
    end
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 2'b00, 1'b0, 16'd0);
  endtask

  // Monitor: grant expectations are consumed once per cycle, read expectations whenever an rvalid appears.
  always @(negedge clk) begin
    gnt_exp_t e;
    rd_exp_t  r;
    if (reset === 1'b1) begin
      if (gnt_q.size() > 0) begin
        e = gnt_q.pop_front();
        check_output("grant_cycle", 32'(cyc), 32'(e.cyc));
        check_output("grant", {30'd0, bus.b_gnt, bus.a_gnt}, {30'd0, e.gnt});
        check_output("mem_en", {31'd0, bus.mem_en}, {31'd0, (e.gnt != 2'b00)});
        check_output("mem_we", {31'd0, bus.mem_we}, {31'd0, e.we});
        check_output("mem_addr", {16'd0, bus.mem_addr}, {16'd0, e.addr});
        check_output("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, e.wdata});
      end else begin
        check_output("unexpected_grant", {30'd0, bus.b_gnt, bus.a_gnt}, 32'd0);
      end
      if (bus.a_rvalid || bus.b_rvalid) begin
        if (rd_q.size() == 0) begin
          check_output("spurious_rvalid", {30'd0, bus.b_rvalid, bus.a_rvalid}, 32'd0);
        end else begin
          r = rd_q.pop_front();
          check_output("rvalid_cycle", 32'(cyc), 32'(r.cyc));
          check_output("rvalid_port", {30'd0, bus.b_rvalid, bus.a_rvalid}, {30'd0, r.port});
          check_output("rdata", {16'd0, (r.port == 2'b10) ? bus.b_rdata : bus.a_rdata}, {16'd0, r.data});
        end
      end
      check_output("busy", {31'd0, bus.busy}, {31'd0, bus.a_rvalid | bus.b_rvalid});
    end
  end

  initial begin
    logic [1:0] pat [0:9];
    int         a_cnt;
    int         b_cnt;

    for (int i = 0; i < 65536; i++) mem_model[i] = 16'd0;
    mem_model[16'h0010] = 16'h1234;
    mem_model[16'h0001] = 16'hAAAA;
    mem_model[16'h0002] = 16'hBBBB;
    mem_model[16'h0003] = 16'h3333;

    reset = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 16'h0055; bus.a_wdata = 16'h5555;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h0066; bus.b_wdata = 16'h6666;
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_a_gnt", {31'd0, bus.a_gnt}, 32'd0);
    check_output("rst_b_gnt", {31'd0, bus.b_gnt}, 32'd0);
    check_output("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check_output("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;

    // A alone reads, then the held read data is checked once rvalid has dropped.
    apply_stimulus(1'b1, 1'b0, 16'h0010, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 2'b01, 1'b1, 16'h1234);
    idle();
    idle();
    check_output("a_rdata_hold", {16'd0, bus.a_rdata}, 32'h1234);
    check_output("a_rvalid_low", {31'd0, bus.a_rvalid}, 32'd0);

    // B write followed by A read of the same word.
    apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 2'b10, 1'b0, 16'd0);
    apply_stimulus(1'b1, 1'b0, 16'h0100, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 2'b01, 1'b1, 16'hBEEF);
    idle();

    // Back-to-back reads from different requesters.
    apply_stimulus(1'b1, 1'b0, 16'h0001, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 2'b01, 1'b1, 16'hAAAA);
    apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 16'h0002, 16'd0, 2'b10, 1'b1, 16'hBBBB);
    idle();
    idle();

    // Read at t is unaffected by a write to the same word at t+1.
    apply_stimulus(1'b1, 1'b0, 16'h0003, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 2'b01, 1'b1, 16'h3333);
    apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 16'h0003, 16'h5555, 2'b10, 1'b0, 16'd0);
    apply_stimulus(1'b1, 1'b0, 16'h0003, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 2'b01, 1'b1, 16'h5555);
    idle();

    // Continuous contention: A four times, then the starved B.
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    a_cnt = 0;
    b_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b1, 16'(16'h0200 + a_cnt), 16'(16'hA000 + a_cnt),
                     1'b1, 1'b1, 16'h0300, 16'(16'hB000 + b_cnt), pat[i], 1'b0, 16'd0);
      if (pat[i] == 2'b01) a_cnt++;
      else                 b_cnt++;
    end
    idle();

    // B requests three cycles then withdraws; its counter must restart from zero afterwards.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b1, 16'(16'h0400 + i), 16'(i), (i < 3), 1'b1, 16'h0500, 16'hCAFE,
                     2'b01, 1'b0, 16'd0);
    end
    a_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b1, 16'(16'h0410 + a_cnt), 16'(16'hD000 + a_cnt),
                     1'b1, 1'b1, 16'h0510, 16'hCAFE, pat[i], 1'b0, 16'd0);
      if (pat[i] == 2'b01) a_cnt++;
    end
    idle();

    // Reset the cycle after an A read grant: the read must vanish.
    apply_stimulus(1'b1, 1'b0, 16'h0010, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 2'b01, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    #1;
    check_output("mid_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
    check_output("mid_b_rvalid", {31'd0, bus.b_rvalid}, 32'd0);
    check_output("mid_a_rdata", {16'd0, bus.a_rdata}, 32'd0);
    check_output("mid_b_rdata", {16'd0, bus.b_rdata}, 32'd0);
    check_output("mid_gnt", {30'd0, bus.b_gnt, bus.a_gnt}, 32'd0);
    check_output("mid_mem_en_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd0);
    check_output("mid_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    check_output("mid_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    check_output("mid_busy", {31'd0, bus.busy}, 32'd0);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    held_addr = 16'd0;
    held_wdata = 16'd0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 16'h0002, 16'd0, 2'b10, 1'b1, 16'hBBBB);
    idle();
    idle();
    check_output("b_rdata_hold", {16'd0, bus.b_rdata}, 32'hBBBB);
    check_output("a_rdata_after_rst", {16'd0, bus.a_rdata}, 32'd0);

    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("grant_queue_drained", 32'(gnt_q.size()), 32'd0);
    check_output("read_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive cycles requester B may be denied while requesting; legal range 1-15.
REQ-002 Parameter AW, default 16: address width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 a_req  input  1  requester A (pipeline memory stage) access request.
REQ-006 a_we  input  1  A write enable (1 = store, 0 = load).
REQ-007 a_addr  input  AW  A word address.
REQ-008 a_wdata  input  16  A store data.
REQ-009 a_gnt  output  1  A access accepted this cycle.
REQ-010 a_rvalid  output  1  A load data valid.
REQ-011 a_rdata  output  16  A load data.
REQ-012 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same widths, directions and meanings as the A signals, for requester B (loader/debug port).
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write strobe.
REQ-015 mem_addr  output  AW  memory word address.
REQ-016 mem_wdata  output  16  memory write data.
REQ-017 mem_rdata  input  16  memory read data, valid exactly 1 cycle after a read strobe.
REQ-018 busy  output  1  a read is outstanding this cycle (rvalid pending).

Function
REQ-019 Grants are combinational from the current requests and registered arbiter state; at most one of a_gnt/b_gnt is high in any cycle.
REQ-020 Default priority: A wins when both request, unless the starve counter equals STARVE_LIMIT, in which case B wins.
REQ-021 Lone requester: whichever single requester is active is granted the same cycle.
REQ-022 Starve counter (4 bits): +1 each cycle b_req=1 and b_gnt=0; cleared to 0 on b_gnt or when b_req=0; saturates at STARVE_LIMIT.
REQ-023 Grant cycle: mem_en=1; mem_we, mem_addr and mem_wdata are muxed from the granted requester.
REQ-024 No grant: mem_en=0, mem_we=0, mem_addr and mem_wdata hold their last driven values.
REQ-025 Read return: a granted read (we=0) at cycle t raises that requester's rvalid at t+1 only, with rdata = mem_rdata sampled at t+1.
REQ-026 Read return tag: a 1-bit registered owner tag records which requester's read is in flight.
REQ-027 rdata outputs hold their value when rvalid=0.
REQ-028 Writes return nothing; rvalid stays 0 for a write grant.
REQ-029 Back-to-back: a new grant is allowed at t+1 while the read from t returns, giving 1 access per cycle sustained.
REQ-030 Cross-requester ordering: a write at t+1 to the same address as a read at t does not affect the t read data, because memory is read-before-write ordered.
REQ-031 busy = 1 in any cycle where an rvalid is being delivered.
REQ-032 Requests are level-sensitive: a requester holds req/we/addr/wdata stable until it sees gnt.
REQ-033 Request drop: if req falls before gnt, no access occurs.

Reset
REQ-034 reset=0 asynchronously forces: starve counter=0, owner tag=A, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, mem_addr=mem_wdata=0, busy=0.
REQ-035 While reset=0: a_gnt=b_gnt=0 and mem_en=mem_we=0 regardless of requests.
REQ-036 Reset mid-read: an in-flight read is discarded and no rvalid is produced after reset release.
REQ-037 After reset release: the first posedge honours requests normally.

Verification
REQ-038 A alone reads addr 0x0010 with memory[0x0010]=0x1234 -> a_gnt same cycle, a_rvalid=1 with a_rdata=0x1234 next cycle, b_* stay 0.
REQ-039 A and B both request continuously, STARVE_LIMIT=4 -> grant pattern A,A,A,A,B repeating; B starve counter never exceeds 4.
REQ-040 B writes 0xBEEF to 0x0100, then A reads 0x0100 in the following cycle -> a_rdata=0xBEEF.
REQ-041 A reads 0x0001 at t, B reads 0x0002 at t+1 (memory 0xAAAA/0xBBBB) -> a_rvalid at t+1 with 0xAAAA, b_rvalid at t+2 with 0xBBBB, never both in one cycle.
REQ-042 reset asserted low the cycle after an A read grant -> a_rvalid never rises, all outputs at REQ-034/035 values, normal grant on first posedge after release.
REQ-043 b_req raised 3 cycles then dropped while A continuously requests -> B never granted, starve counter returns to 0 on drop.
